// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one single-port synchronous RAM between two requesters.
// Commands arrive over valid/ready, are issued to the RAM from registers, and
// read results come back to the issuing port a fixed 3 cycles after handshake.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always
// wins on contention, port 1 may starve); default is round-robin.
module ram_rr_arbiter #(
   parameter int AW = 3,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   input  logic          req0_rw,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   output logic          rd0_valid,
   output logic [DW-1:0] rd0_data,
   input  logic          req1_valid,
   input  logic          req1_rw,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          rd1_valid,
   output logic [DW-1:0] rd1_data,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rw,
   output logic [DW-1:0] ram_data_in,
   input  logic [DW-1:0] ram_data_out
);

   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_xfer;
   logic          w_sel_rw;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_data;

   logic          r_ram_rw;
   logic [AW-1:0] r_ram_addr;
   logic [DW-1:0] r_ram_din;

   logic          r_tag_vld_p0;
   logic          r_tag_id_p0;
   logic          r_tag_vld_p1;
   logic          r_tag_id_p1;

   logic          r_rd0_valid;
   logic [DW-1:0] r_rd0_data;
   logic          r_rd1_valid;
   logic [DW-1:0] r_rd1_data;

`ifndef RAM_ARB_FIXED_PRIO_EN
   logic          r_prio;
`endif

   // Grant decision: at most one ready per cycle, none while reset is held
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (reset) begin
         if (req0_valid && req1_valid) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w_gnt0 = 1'b1;
`else
            w_gnt0 = ~r_prio;
            w_gnt1 = r_prio;
`endif
         end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
         end
      end
   end

   assign w_xfer     = w_gnt0 | w_gnt1;
   assign w_sel_rw   = w_gnt1 ? req1_rw   : req0_rw;
   assign w_sel_addr = w_gnt1 ? req1_addr : req0_addr;
   assign w_sel_data = w_gnt1 ? req1_data : req0_data;

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Priority pointer: after a transfer, favour the port that was not served
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_prio <= 1'b0;
      end else if (w_xfer) begin
         r_prio <= w_gnt0;
      end
   end
`endif

   // Stage p0: issue accepted command to the RAM; idle cycles become reads so the RAM never writes spuriously
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ram_rw   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
      end else if (w_xfer) begin
         r_ram_rw   <= w_sel_rw;
         r_ram_addr <= w_sel_addr;
         r_ram_din  <= w_sel_data;
      end else begin
         r_ram_rw   <= 1'b0;
      end
   end

   // Stage p0 -> p1: read tag follows its command while the RAM samples it
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tag_vld_p0 <= 1'b0;
         r_tag_id_p0  <= 1'b0;
         r_tag_vld_p1 <= 1'b0;
         r_tag_id_p1  <= 1'b0;
      end else begin
         r_tag_vld_p0 <= w_xfer & ~w_sel_rw;
         r_tag_id_p0  <= w_gnt1;
         r_tag_vld_p1 <= r_tag_vld_p0;
         r_tag_id_p1  <= r_tag_id_p0;
      end
   end

   // Stage p2: steer RAM output to the issuing port; data holds between pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd0_valid <= 1'b0;
         r_rd0_data  <= '0;
         r_rd1_valid <= 1'b0;
         r_rd1_data  <= '0;
      end else begin
         r_rd0_valid <= r_tag_vld_p1 & ~r_tag_id_p1;
         r_rd1_valid <= r_tag_vld_p1 &  r_tag_id_p1;
         if (r_tag_vld_p1 && !r_tag_id_p1) begin
            r_rd0_data <= ram_data_out;
         end
         if (r_tag_vld_p1 && r_tag_id_p1) begin
            r_rd1_data <= ram_data_out;
         end
      end
   end

   assign ram_addr    = r_ram_addr;
   assign ram_rw      = r_ram_rw;
   assign ram_data_in = r_ram_din;
   assign rd0_valid   = r_rd0_valid;
   assign rd0_data    = r_rd0_data;
   assign rd1_valid   = r_rd1_valid;
   assign rd1_data    = r_rd1_data;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Testbench for ram_rr_arbiter: directed table, hand sequences and random
// traffic, all checked against a transaction-level model of the arbiter+RAM.
module tb_ram_rr_arbiter;

   localparam bit FX =
`ifdef RAM_ARB_FIXED_PRIO_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       req0_valid, req0_rw, req0_ready, rd0_valid;
   logic [2:0] req0_addr;
   logic [3:0] req0_data, rd0_data;
   logic       req1_valid, req1_rw, req1_ready, rd1_valid;
   logic [2:0] req1_addr;
   logic [3:0] req1_data, rd1_data;
   logic [2:0] ram_addr;
   logic       ram_rw;
   logic [3:0] ram_data_in, ram_data_out;

   ram_rr_arbiter #(.AW(3), .DW(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_ready(req0_ready),
      .rd0_valid(rd0_valid), .rd0_data(rd0_data),
      .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_ready(req1_ready),
      .rd1_valid(rd1_valid), .rd1_data(rd1_data),
      .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM with registered output, cleared by reset
   logic [3:0] ram_mem [8];
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) ram_mem[i] <= 4'h0;
         ram_data_out <= 4'h0;
      end else begin
         if (ram_rw) ram_mem[ram_addr] <= ram_data_in;
         ram_data_out <= ram_mem[ram_addr];
      end
   end

   // Reference model: memory contents in acceptance order, expected responses by cycle
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [3:0] m_mem [8];
   logic       m_prio;
   logic       m_ev0 [8];
   logic       m_ev1 [8];
   logic [3:0] m_ed0 [8];
   logic [3:0] m_ed1 [8];
   logic [2:0] m_ram_addr;
   logic       m_ram_rw;
   logic [3:0] m_ram_din;
   logic [3:0] m_rd0_data, m_rd1_data;

   // Last sampled values, for hand-written checks
   logic       s_r0, s_r1, s_rd0v, s_rd1v, s_ramrw, s_x0, s_x1;
   logic [3:0] s_rd0d, s_rd1d;

   typedef struct {
      logic       v0; logic rw0; logic [2:0] a0; logic [3:0] d0;
      logic       v1; logic rw1; logic [2:0] a1; logic [3:0] d1;
      logic       e0; logic e1;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_mem[i] = 4'h0; m_ev0[i] = 1'b0; m_ev1[i] = 1'b0;
         m_ed0[i] = 4'h0; m_ed1[i] = 4'h0;
      end
      m_prio = 1'b0; m_ram_addr = 3'd0; m_ram_rw = 1'b0; m_ram_din = 4'h0;
      m_rd0_data = 4'h0; m_rd1_data = 4'h0;
   endtask

   task automatic set0(input logic v, input logic rw, input logic [2:0] a, input logic [3:0] d);
      req0_valid = v; req0_rw = rw; req0_addr = a; req0_data = d;
   endtask

   task automatic set1(input logic v, input logic rw, input logic [2:0] a, input logic [3:0] d);
      req1_valid = v; req1_rw = rw; req1_addr = a; req1_data = d;
   endtask

   // One clock cycle: sample at negedge, compare with model, advance model past the posedge
   task automatic step(input logic chk, input logic e0, input logic e1);
      logic       mr0, mr1, p, rw;
      logic [2:0] slot, slot3, a;
      logic [3:0] d;
      @(negedge clk);
      slot  = cyc[2:0];
      slot3 = slot + 3'd3;
      mr0 = 1'b0;
      mr1 = 1'b0;
      if (reset) begin
         if (req0_valid && req1_valid) begin
            mr0 = FX ? 1'b1 : ~m_prio;
            mr1 = ~mr0;
         end else begin
            mr0 = req0_valid;
            mr1 = req1_valid;
         end
      end
      check("ready0", 32'(req0_ready), 32'(mr0));
      check("ready1", 32'(req1_ready), 32'(mr1));
      if (chk) begin
         check("tbl_ready0", 32'(req0_ready), 32'(e0));
         check("tbl_ready1", 32'(req1_ready), 32'(e1));
      end
      if (m_ev0[slot]) m_rd0_data = m_ed0[slot];
      if (m_ev1[slot]) m_rd1_data = m_ed1[slot];
      check("rd0_valid", 32'(rd0_valid), 32'(m_ev0[slot]));
      check("rd1_valid", 32'(rd1_valid), 32'(m_ev1[slot]));
      check("rd0_data", 32'(rd0_data), 32'(m_rd0_data));
      check("rd1_data", 32'(rd1_data), 32'(m_rd1_data));
      check("ram_rw", 32'(ram_rw), 32'(m_ram_rw));
      check("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
      check("ram_data_in", 32'(ram_data_in), 32'(m_ram_din));
      s_r0 = req0_ready; s_r1 = req1_ready; s_ramrw = ram_rw;
      s_rd0v = rd0_valid; s_rd0d = rd0_data; s_rd1v = rd1_valid; s_rd1d = rd1_data;
      s_x0 = mr0; s_x1 = mr1;
      m_ev0[slot] = 1'b0;
      m_ev1[slot] = 1'b0;
      if (!reset) begin
         model_clear();
      end else if (mr0 || mr1) begin
         p  = mr1;
         rw = p ? req1_rw   : req0_rw;
         a  = p ? req1_addr : req0_addr;
         d  = p ? req1_data : req0_data;
         m_ram_addr = a; m_ram_rw = rw; m_ram_din = d;
         if (rw) m_mem[a] = d;
         else if (p) begin m_ev1[slot3] = 1'b1; m_ed1[slot3] = m_mem[a]; end
         else begin m_ev0[slot3] = 1'b1; m_ed0[slot3] = m_mem[a]; end
         m_prio = ~p;
      end else begin
         m_ram_rw = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      model_clear();
      reset = 1'b0;
      set0(1'b0, 1'b0, 3'd0, 4'h0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      repeat (2) @(posedge clk);
      #1;

      // Reset held with both requesters valid: no grants
      set0(1'b1, 1'b1, 3'd3, 4'h5);
      set1(1'b1, 1'b0, 3'd6, 4'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check("rst_ready0", 32'(s_r0), 32'd0);
         check("rst_ready1", 32'(s_r1), 32'd0);
         check("rst_ram_rw", 32'(s_ramrw), 32'd0);
      end
      reset = 1'b1;
      set0(1'b0, 1'b0, 3'd0, 4'h0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      step(1'b0, 1'b0, 1'b0);

      // Port 0 writes 5<=A then reads it back the next cycle
      set0(1'b1, 1'b1, 3'd5, 4'hA);
      step(1'b0, 1'b0, 1'b0);
      set0(1'b1, 1'b0, 3'd5, 4'h0);
      step(1'b0, 1'b0, 1'b0);
      check("wr_issue_rw", 32'(s_ramrw), 32'd1);
      set0(1'b0, 1'b0, 3'd0, 4'h0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("raw_rd0_valid", 32'(s_rd0v), 32'd1);
      check("raw_rd0_data", 32'(s_rd0d), 32'hA);
      check("raw_rd1_valid", 32'(s_rd1v), 32'd0);

      // Preload 1<=3 (port 0) and 2<=7 (port 1); leaves port 0 favoured
      set0(1'b1, 1'b1, 3'd1, 4'h3);
      step(1'b0, 1'b0, 1'b0);
      set0(1'b0, 1'b0, 3'd0, 4'h0);
      set1(1'b1, 1'b1, 3'd2, 4'h7);
      step(1'b0, 1'b0, 1'b0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      step(1'b0, 1'b0, 1'b0);

      // Directed contention / hold-priority table
      tbl[0]  = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, FX, ~FX};
      tbl[2]  = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, FX, ~FX};
      tbl[4]  = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, FX, ~FX};
      tbl[10] = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 3'd2, 4'h0, FX, ~FX};
      tbl[13] = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
      for (int i = 0; i < 16; i++) begin
         set0(tbl[i].v0, tbl[i].rw0, tbl[i].a0, tbl[i].d0);
         set1(tbl[i].v1, tbl[i].rw1, tbl[i].a1, tbl[i].d1);
         step(1'b1, tbl[i].e0, tbl[i].e1);
      end

      // Reset one cycle after a port 1 read is accepted: response is dropped
      set1(1'b1, 1'b1, 3'd4, 4'h9);
      step(1'b0, 1'b0, 1'b0);
      set1(1'b1, 1'b0, 3'd4, 4'h0);
      step(1'b0, 1'b0, 1'b0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check("flush_rd1_valid", 32'(s_rd1v), 32'd0);
      end
      set1(1'b1, 1'b0, 3'd4, 4'h0);
      step(1'b0, 1'b0, 1'b0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("post_rst_rd1_valid", 32'(s_rd1v), 32'd1);
      check("post_rst_rd1_data", 32'(s_rd1d), 32'h0);

`ifdef RAM_ARB_FIXED_PRIO_EN
      // Fixed priority: port 0 wins every contended cycle
      set0(1'b1, 1'b0, 3'd1, 4'h0);
      set1(1'b1, 1'b0, 3'd2, 4'h0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check("fixed_ready0", 32'(s_r0), 32'd1);
         check("fixed_ready1", 32'(s_r1), 32'd0);
      end
      set0(1'b0, 1'b0, 3'd0, 4'h0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      step(1'b0, 1'b0, 1'b0);
`endif

      // Random traffic; requesters hold commands until accepted, occasional reset
      s_x0 = 1'b0;
      s_x1 = 1'b0;
      for (int k = 0; k < 600; k++) begin
         reset = ($urandom_range(0, 59) != 0);
         if (!req0_valid || s_x0)
            set0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         if (!req1_valid || s_x1)
            set1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         step(1'b0, 1'b0, 1'b0);
      end
      reset = 1'b1;
      set0(1'b0, 1'b0, 3'd0, 4'h0);
      set1(1'b0, 1'b0, 3'd0, 4'h0);
      repeat (4) step(1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
